pixel_proc_stage: RTL and testbench
===================================

Name: pixel_proc_stage

Overview:
- Synthesizable point-operation stage that sits directly upstream of the BMP writer.
- Consumes a two-pixels-per-clock RGB888 stream with a per-beat valid strobe and applies a per-channel operation: pass, saturating brighten, saturating darken, or invert.
- Emits the result as the writer's hsync plus R0/G0/B0/R1/G1/B1 bus with fixed 2-cycle latency.
- Tracks column and row position and flags line end and frame completion.

Parameters:
WIDTH, 512, image width in pixels (even; beats per line = WIDTH/2)
HEIGHT, 512, image height in lines
DEF_VALUE, 100, cfg_value used when cfg_value_ovr is low

Ports:
HCLK  in  1  clock, all logic posedge
HRESETn  in  1  reset, asynchronous, active-low
cfg_mode  in  3  operation: 0 pass, 1 add, 2 sub, 3 invert, 4 threshold (optional), 5-7 pass
cfg_value  in  8  brightness delta / threshold level
cfg_value_ovr  in  1  1 = use cfg_value, 0 = use DEF_VALUE
in_valid  in  1  input beat valid (two pixels)
in_R0, in_G0, in_B0  in  8 each  even pixel
in_R1, in_G1, in_B1  in  8 each  odd pixel
hsync  out  1  output beat valid, feeds writer hsync
DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0  out  8 each  processed even pixel
DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1  out  8 each  processed odd pixel
line_end  out  1  pulse with last output beat of each line
frame_done  out  1  pulse with last output beat of frame
busy  out  1  high from first accepted beat until frame_done cycle inclusive

Behaviour:
- Reset (async assert; release sampled on HCLK):
  - All outputs 0.
  - Pipeline valids cleared.
  - Column/row counters 0.
  - Latched config = mode 0, value DEF_VALUE.
- Reset mid-frame:
  - Discards in-flight beats.
  - No frame_done is issued.
  - The next accepted beat is treated as column 0, row 0.
- Config latch:
  - cfg_mode and effective value are sampled on the cycle an in_valid beat is accepted while busy=0 (frame start).
  - Config is held constant for the entire frame; changes mid-frame are ignored.
- Pipeline:
  - Stage 1 registers pixels, valid, and end-of-line/end-of-frame tags.
  - Stage 2 registers the ALU result.
  - in_valid at cycle N gives hsync at N+2. No stalls; full rate, one beat per clock.
- in_valid low inserts a bubble: hsync low, DATA_WRITE_* hold their last value.
- Counters advance on each accepted beat:
  - col runs 0..WIDTH/2-1, then wraps to 0 and increments row.
  - row runs 0..HEIGHT-1.
  - On the last beat (col=WIDTH/2-1, row=HEIGHT-1), both counters wrap to 0.
- Tags are computed at input and travel with the beat:
  - line_end = col==WIDTH/2-1.
  - frame_done = line_end && row==HEIGHT-1.
  - Both pulse exactly one cycle, coincident with the output hsync of that beat.
- busy:
  - Rises the cycle after the first accepted beat.
  - Falls the cycle after frame_done.
  - A beat arriving on the frame_done cycle starts a new frame and re-latches config; busy stays high.
- Arithmetic, per channel with a 9-bit intermediate:
  - add = min(255, p+v).
  - sub = max(0, p-v).
  - invert = 255-p.
  - pass = p.

Optional Feature:
- PIX_THRESHOLD_EN defined:
  - mode 4 computes a 10-bit sum s = R+G+B per pixel.
  - If s > 3*v (10-bit compare), all three channels = 255; else all = 0.
  - Each pixel of the pair is evaluated independently.
- PIX_THRESHOLD_EN undefined: mode 4 behaves as pass; no threshold logic is synthesized.

Decomposition:
- Package pix_pkg holds:
  - PIX_W=8 constant.
  - Mode encodings MODE_PASS/ADD/SUB/INV/THR.
  - Saturating add/sub functions.
- Sub-module pix_alu: combinational single-pixel (R,G,B) operation with mode and value inputs. Instantiated twice (even/odd pixel) inside stage 2 logic.

Test Plan:
- Reset then mode 1, value 100, WIDTH=4, HEIGHT=2, 4 consecutive beats with in_R0=200, in_G0=50, in_B0=0:
  - Each beat yields R0=255, G0=150, B0=100 two cycles after its in_valid.
  - line_end on output beats 2 and 4; frame_done on beat 4 only.
- Mode 2, value 30, pixel (10,40,255):
  - Outputs (0,10,225).
  - Mode 3 on the same pixel gives (245,215,0).
- Bubble pattern in_valid = 1,0,1:
  - hsync = 1,0,1 delayed by 2.
  - Data held during the bubble.
  - Counters advance only twice.
- Change cfg_mode from 1 to 3 after the first beat of a frame:
  - Every beat of that frame still uses add.
  - The next frame uses invert.
- Assert HRESETn low mid-line, with 2 beats in flight:
  - Outputs go to 0 immediately and in-flight hsync is lost.
  - After release, frame_done occurs exactly WIDTH*HEIGHT/2 beats later.
- With PIX_THRESHOLD_EN, mode 4, value 90:
  - Pixel (100,100,71) (s=271) gives 255s; pixel (90,90,90) (s=270) gives 0s.
  - Without the macro, mode 4 passes the pixel unchanged.

Source files
------------

// File: rtl/pix_pkg.sv
// -----------------------------------------------------------------------------
// pix_pkg
//   Shared definitions for the pixel point-operation stage: channel width,
//   operation mode encodings and saturating channel arithmetic.
// -----------------------------------------------------------------------------
package pix_pkg;

    localparam int unsigned PIX_W = 8;

    // Codes 5..7 carry no enum label; the ALU treats them as pass.
    typedef enum logic [2:0] {
        MODE_PASS = 3'd0,
        MODE_ADD  = 3'd1,
        MODE_SUB  = 3'd2,
        MODE_INV  = 3'd3,
        MODE_THR  = 3'd4
    } pix_mode_e;

    // min(255, p + v) using a 9-bit intermediate
    function automatic logic [PIX_W-1:0] sat_add(input logic [PIX_W-1:0] p,
                                                 input logic [PIX_W-1:0] v);
        logic [PIX_W:0] s;
        s = {1'b0, p} + {1'b0, v};
        return s[PIX_W] ? '1 : s[PIX_W-1:0];
    endfunction

    // max(0, p - v); bit 8 of the 9-bit difference is the borrow
    function automatic logic [PIX_W-1:0] sat_sub(input logic [PIX_W-1:0] p,
                                                 input logic [PIX_W-1:0] v);
        logic [PIX_W:0] s;
        s = {1'b0, p} - {1'b0, v};
        return s[PIX_W] ? '0 : s[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/pixel_proc_stage_if.sv
// -----------------------------------------------------------------------------
// pixel_proc_stage_if
//   Pixel stream bundle around pixel_proc_stage.
//   Upstream side : in_valid, in_R0/G0/B0 (even pixel), in_R1/G1/B1 (odd pixel)
//   Writer side   : hsync, DATA_WRITE_R0/G0/B0, DATA_WRITE_R1/G1/B1
//   modport master : the pixel source / writer sink (drives in_*)
//   modport slave  : the processing stage (consumes in_*, drives writer bus)
// -----------------------------------------------------------------------------
interface pixel_proc_stage_if;
    import pix_pkg::*;

    logic             in_valid;
    logic [PIX_W-1:0] in_R0, in_G0, in_B0;
    logic [PIX_W-1:0] in_R1, in_G1, in_B1;

    logic             hsync;
    logic [PIX_W-1:0] DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0;
    logic [PIX_W-1:0] DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1;

    modport master (
        output in_valid, in_R0, in_G0, in_B0, in_R1, in_G1, in_B1,
        input  hsync,
        input  DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0,
        input  DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1
    );

    modport slave (
        input  in_valid, in_R0, in_G0, in_B0, in_R1, in_G1, in_B1,
        output hsync,
        output DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0,
        output DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1
    );

endinterface

// File: rtl/pix_alu.sv
// -----------------------------------------------------------------------------
// pix_alu
//   Combinational point operation on one RGB888 pixel.
//   Inputs : mode_i (operation), value_i (delta / threshold level), r_i/g_i/b_i
//   Outputs: r_o/g_o/b_o
//   Optional macro PIX_THRESHOLD_EN: enables MODE_THR (R+G+B > 3*value -> white,
//   else black). Without it MODE_THR falls through to pass.
// -----------------------------------------------------------------------------
module pix_alu
    import pix_pkg::*;
(
    input  pix_mode_e        mode_i,
    input  logic [PIX_W-1:0] value_i,
    input  logic [PIX_W-1:0] r_i,
    input  logic [PIX_W-1:0] g_i,
    input  logic [PIX_W-1:0] b_i,
    output logic [PIX_W-1:0] r_o,
    output logic [PIX_W-1:0] g_o,
    output logic [PIX_W-1:0] b_o
);

`ifdef PIX_THRESHOLD_EN
    logic [PIX_W+1:0] sum;
    logic [PIX_W+1:0] level;

    assign sum   = {2'b00, r_i} + {2'b00, g_i} + {2'b00, b_i};
    // 3*v as v + 2*v, all in 10 bits
    assign level = {2'b00, value_i} + {1'b0, value_i, 1'b0};
`endif

    always_comb begin
        r_o = r_i;
        g_o = g_i;
        b_o = b_i;
        case (mode_i)
            MODE_ADD: begin
                r_o = sat_add(r_i, value_i);
                g_o = sat_add(g_i, value_i);
                b_o = sat_add(b_i, value_i);
            end
            MODE_SUB: begin
                r_o = sat_sub(r_i, value_i);
                g_o = sat_sub(g_i, value_i);
                b_o = sat_sub(b_i, value_i);
            end
            MODE_INV: begin
                r_o = ~r_i;
                g_o = ~g_i;
                b_o = ~b_i;
            end
`ifdef PIX_THRESHOLD_EN
            MODE_THR: begin
                r_o = (sum > level) ? '1 : '0;
                g_o = (sum > level) ? '1 : '0;
                b_o = (sum > level) ? '1 : '0;
            end
`endif
            default: begin
                r_o = r_i;
                g_o = g_i;
                b_o = b_i;
            end
        endcase
    end

endmodule

// File: rtl/pixel_proc_stage.sv
// -----------------------------------------------------------------------------
// pixel_proc_stage
//   Two-pixel-per-clock RGB888 point-operation stage feeding the BMP writer.
//   Fixed 2-cycle latency (stage 1: pixels + position tags, stage 2: ALU
//   result), no stalls. Config is latched at frame start and held all frame.
//   Ports:
//     HCLK, HRESETn          clock, async active-low reset
//     cfg_mode/cfg_value/cfg_value_ovr   operation and delta/threshold
//     bus (slave)            in_* beat input, hsync + DATA_WRITE_* output
//     line_end, frame_done   one-cycle tags aligned with hsync of that beat
//     busy                   frame in progress
//   Optional macro PIX_THRESHOLD_EN: threshold operation for mode 4.
// -----------------------------------------------------------------------------
module pixel_proc_stage
    import pix_pkg::*;
#(
    parameter int unsigned WIDTH     = 512,
    parameter int unsigned HEIGHT    = 512,
    parameter int unsigned DEF_VALUE = 100
)
(
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic [2:0]       cfg_mode,
    input  logic [PIX_W-1:0] cfg_value,
    input  logic             cfg_value_ovr,
    pixel_proc_stage_if.slave bus,
    output logic             line_end,
    output logic             frame_done,
    output logic             busy
);

    localparam int unsigned BEATS = WIDTH / 2;
    localparam int unsigned COL_W = (BEATS  > 1) ? $clog2(BEATS)  : 1;
    localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(BEATS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    pix_mode_e          mode_q, mode_d;
    logic [PIX_W-1:0]   val_q, val_d;
    logic               busy_q, busy_d;

    logic               s1_valid_q;
    logic               s1_eol_q, s1_eof_q;
    logic [6*PIX_W-1:0] s1_pix_q;

    logic               hsync_q, line_end_q, frame_done_q;
    logic [6*PIX_W-1:0] out_pix_q, out_pix_d;
    logic [6*PIX_W-1:0] alu_pix;

    logic               eol, eof, start;

    assign eol = (col_q == LAST_COL);
    assign eof = eol && (row_q == LAST_ROW);
    // A beat landing on the frame_done cycle opens the next frame even
    // though busy has not dropped yet.
    assign start = bus.in_valid && (!busy_q || frame_done_q);

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        mode_d = mode_q;
        val_d  = val_q;
        busy_d = busy_q;
        if (bus.in_valid) begin
            if (eol) begin
                col_d = '0;
                row_d = eof ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        if (start) begin
            mode_d = pix_mode_e'(cfg_mode);
            val_d  = cfg_value_ovr ? cfg_value : PIX_W'(DEF_VALUE);
        end
        if (frame_done_q) begin
            busy_d = 1'b0;
        end
        if (bus.in_valid) begin
            busy_d = 1'b1;
        end
    end

    // Stage 2 data only updates on a valid beat so bubbles hold the bus.
    assign out_pix_d = s1_valid_q ? alu_pix : out_pix_q;

    pix_alu u_alu_even (
        .mode_i  (mode_q),
        .value_i (val_q),
        .r_i     (s1_pix_q[6*PIX_W-1:5*PIX_W]),
        .g_i     (s1_pix_q[5*PIX_W-1:4*PIX_W]),
        .b_i     (s1_pix_q[4*PIX_W-1:3*PIX_W]),
        .r_o     (alu_pix[6*PIX_W-1:5*PIX_W]),
        .g_o     (alu_pix[5*PIX_W-1:4*PIX_W]),
        .b_o     (alu_pix[4*PIX_W-1:3*PIX_W])
    );

    pix_alu u_alu_odd (
        .mode_i  (mode_q),
        .value_i (val_q),
        .r_i     (s1_pix_q[3*PIX_W-1:2*PIX_W]),
        .g_i     (s1_pix_q[2*PIX_W-1:PIX_W]),
        .b_i     (s1_pix_q[PIX_W-1:0]),
        .r_o     (alu_pix[3*PIX_W-1:2*PIX_W]),
        .g_o     (alu_pix[2*PIX_W-1:PIX_W]),
        .b_o     (alu_pix[PIX_W-1:0])
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            col_q        <= '0;
            row_q        <= '0;
            mode_q       <= MODE_PASS;
            val_q        <= PIX_W'(DEF_VALUE);
            busy_q       <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_eol_q     <= 1'b0;
            s1_eof_q     <= 1'b0;
            s1_pix_q     <= '0;
            hsync_q      <= 1'b0;
            line_end_q   <= 1'b0;
            frame_done_q <= 1'b0;
            out_pix_q    <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            mode_q       <= mode_d;
            val_q        <= val_d;
            busy_q       <= busy_d;
            s1_valid_q   <= bus.in_valid;
            s1_eol_q     <= bus.in_valid && eol;
            s1_eof_q     <= bus.in_valid && eof;
            s1_pix_q     <= {bus.in_R0, bus.in_G0, bus.in_B0,
                             bus.in_R1, bus.in_G1, bus.in_B1};
            hsync_q      <= s1_valid_q;
            line_end_q   <= s1_eol_q;
            frame_done_q <= s1_eof_q;
            out_pix_q    <= out_pix_d;
        end
    end

    assign bus.hsync         = hsync_q;
    assign bus.DATA_WRITE_R0 = out_pix_q[6*PIX_W-1:5*PIX_W];
    assign bus.DATA_WRITE_G0 = out_pix_q[5*PIX_W-1:4*PIX_W];
    assign bus.DATA_WRITE_B0 = out_pix_q[4*PIX_W-1:3*PIX_W];
    assign bus.DATA_WRITE_R1 = out_pix_q[3*PIX_W-1:2*PIX_W];
    assign bus.DATA_WRITE_G1 = out_pix_q[2*PIX_W-1:PIX_W];
    assign bus.DATA_WRITE_B1 = out_pix_q[PIX_W-1:0];
    assign line_end          = line_end_q;
    assign frame_done        = frame_done_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_pixel_proc_stage.sv
// -----------------------------------------------------------------------------
// tb_pixel_proc_stage
//   Self-checking bench for pixel_proc_stage with a 4x2 image. A reference
//   model tracks the beat index within the frame, the frame's config and a
//   queue of expected output beats due two clocks after acceptance.
// -----------------------------------------------------------------------------
module tb_pixel_proc_stage;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int BPF = W * H / 2;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic [2:0] cfg_mode;
    logic [7:0] cfg_value;
    logic       cfg_value_ovr;
    logic       line_end, frame_done, busy;

    pixel_proc_stage_if bus ();

    pixel_proc_stage #(.WIDTH(W), .HEIGHT(H), .DEF_VALUE(100)) dut (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .cfg_mode      (cfg_mode),
        .cfg_value     (cfg_value),
        .cfg_value_ovr (cfg_value_ovr),
        .bus           (bus),
        .line_end      (line_end),
        .frame_done    (frame_done),
        .busy          (busy)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        int          due;
        logic [50:0] vec;   // hsync, line_end, frame_done, 48-bit data
    } exp_t;

    exp_t        q[$];
    int          cyc, n_cmp, n_mis;
    int          mdl_k, mdl_mode, mdl_val;
    logic [47:0] exp_data;
    logic [51:0] exp_vec, obs_vec;

    function automatic int ref_ch(input int m, input int v, input int p);
        case (m)
            1:       return (p + v > 255) ? 255 : p + v;
            2:       return (p - v < 0) ? 0 : p - v;
            3:       return 255 - p;
            default: return p;
        endcase
    endfunction

    function automatic logic [23:0] ref_px(input int m, input int v, input logic [23:0] px);
        int r, g, b;
        r = int'(px[23:16]);
        g = int'(px[15:8]);
        b = int'(px[7:0]);
`ifdef PIX_THRESHOLD_EN
        if (m == 4) return (r + g + b > 3 * v) ? 24'hFFFFFF : 24'h000000;
`endif
        return {8'(ref_ch(m, v, r)), 8'(ref_ch(m, v, g)), 8'(ref_ch(m, v, b))};
    endfunction

    function automatic logic [47:0] rand48();
        logic [47:0] r;
        r[31:0]  = $urandom();
        r[47:32] = 16'($urandom());
        return r;
    endfunction

    // Apply one cycle of stimulus, advance the model, sample the DUT.
    task automatic drive(input logic vld, input logic [47:0] pix);
        exp_t e;
        logic exp_busy;
        bus.in_valid = vld;
        {bus.in_R0, bus.in_G0, bus.in_B0, bus.in_R1, bus.in_G1, bus.in_B1} = pix;
        @(posedge HCLK);
        #1;
        cyc++;
        if (vld) begin
            if (mdl_k == 0) begin
                mdl_mode = int'(cfg_mode);
                mdl_val  = cfg_value_ovr ? int'(cfg_value) : 100;
            end
            e.due = cyc + 1;
            e.vec = {1'b1, (mdl_k % (W / 2)) == (W / 2 - 1), mdl_k == BPF - 1,
                     ref_px(mdl_mode, mdl_val, pix[47:24]),
                     ref_px(mdl_mode, mdl_val, pix[23:0])};
            q.push_back(e);
            mdl_k = (mdl_k + 1) % BPF;
        end
        exp_busy = (mdl_k != 0) || (q.size() != 0);
        if (q.size() != 0 && q[0].due == cyc) begin
            e = q.pop_front();
            exp_data = e.vec[47:0];
            exp_vec  = {exp_busy, e.vec};
        end else begin
            exp_vec = {exp_busy, 3'b000, exp_data};
        end
        obs_vec = {busy, bus.hsync, line_end, frame_done,
                   bus.DATA_WRITE_R0, bus.DATA_WRITE_G0, bus.DATA_WRITE_B0,
                   bus.DATA_WRITE_R1, bus.DATA_WRITE_G1, bus.DATA_WRITE_B1};
    endtask

    task automatic model_reset();
        q.delete();
        mdl_k    = 0;
        exp_data = '0;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        bus.in_valid = 1'b0;
        {bus.in_R0, bus.in_G0, bus.in_B0, bus.in_R1, bus.in_G1, bus.in_B1} = '0;
        cfg_mode = 3'd0; cfg_value = 8'd0; cfg_value_ovr = 1'b0;
        model_reset();
        #2;
        obs_vec = {busy, bus.hsync, line_end, frame_done,
                   bus.DATA_WRITE_R0, bus.DATA_WRITE_G0, bus.DATA_WRITE_B0,
                   bus.DATA_WRITE_R1, bus.DATA_WRITE_G1, bus.DATA_WRITE_B1};
        n_cmp++;
        if (obs_vec !== 52'd0) begin
            n_mis++;
            $display("FAIL reset_state got=%h exp=%h", obs_vec, 52'd0);
        end
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
    endtask

    task automatic test_add_default();
        logic [47:0] pix;
        cfg_mode = 3'd1; cfg_value = 8'd7; cfg_value_ovr = 1'b0;
        for (int i = 0; i < 7; i++) begin
            pix = {8'd200, 8'd50, 8'd0, rand48()[23:0]};
            drive(i < 4, pix);
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_mis++;
                $display("FAIL add cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
            if (i >= 1 && i <= 4) begin
                n_cmp++;
                if (obs_vec[47:24] !== 24'hFF9664) begin
                    n_mis++;
                    $display("FAIL add_const beat=%0d got=%h exp=%h", i, obs_vec[47:24], 24'hFF9664);
                end
            end
        end
    endtask

    task automatic test_sub_inv();
        logic [23:0] want;
        for (int f = 0; f < 2; f++) begin
            cfg_mode = (f == 0) ? 3'd2 : 3'd3; cfg_value = 8'd30; cfg_value_ovr = 1'b1;
            want = (f == 0) ? 24'h000AE1 : 24'hF5D700;
            for (int i = 0; i < 7; i++) begin
                drive(i < 4, {8'd10, 8'd40, 8'd255, rand48()[23:0]});
                n_cmp++;
                if (obs_vec !== exp_vec) begin
                    n_mis++;
                    $display("FAIL sub_inv cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
                end
                if (i >= 1 && i <= 4) begin
                    n_cmp++;
                    if (obs_vec[47:24] !== want) begin
                        n_mis++;
                        $display("FAIL sub_inv_const f=%0d got=%h exp=%h", f, obs_vec[47:24], want);
                    end
                end
            end
        end
    endtask

    task automatic test_bubble();
        int  sent;
        logic v;
        cfg_mode = 3'd1; cfg_value = 8'($urandom_range(0, 255)); cfg_value_ovr = 1'b1;
        sent = 0;
        // fixed 1,0,1 lead-in, then random gaps until two whole frames are sent
        for (int i = 0; i < 40; i++) begin
            if (i < 3)           v = (i != 1);
            else if (sent < 2 * BPF) v = ($urandom_range(0, 2) != 0);
            else                 v = 1'b0;
            if (v) sent++;
            drive(v, rand48());
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_mis++;
                $display("FAIL bubble cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_cfg_hold();
        cfg_value = 8'd60; cfg_value_ovr = 1'b1;
        for (int i = 0; i < 14; i++) begin
            cfg_mode = (i == 0) ? 3'd1 : 3'd3;
            drive((i < 4) || (i >= 7 && i < 11), rand48());
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_mis++;
                $display("FAIL cfg_hold cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_reset_midframe();
        cfg_mode = 3'd2; cfg_value = 8'd5; cfg_value_ovr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, rand48());
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_mis++;
                $display("FAIL rst_mid_pre cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
        end
        bus.in_valid = 1'b0;
        HRESETn = 1'b0;
        #1;
        obs_vec = {busy, bus.hsync, line_end, frame_done,
                   bus.DATA_WRITE_R0, bus.DATA_WRITE_G0, bus.DATA_WRITE_B0,
                   bus.DATA_WRITE_R1, bus.DATA_WRITE_G1, bus.DATA_WRITE_B1};
        n_cmp++;
        if (obs_vec !== 52'd0) begin
            n_mis++;
            $display("FAIL rst_mid_async got=%h exp=%h", obs_vec, 52'd0);
        end
        repeat (2) @(posedge HCLK);
        #1;
        cyc += 2;
        HRESETn = 1'b1;
        model_reset();
        for (int i = 0; i < BPF + 3; i++) begin
            drive(i < BPF, rand48());
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_mis++;
                $display("FAIL rst_mid_post cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_back_to_back();
        cfg_mode = 3'd3; cfg_value = 8'd0; cfg_value_ovr = 1'b1;
        // three frames with no gaps
        for (int i = 0; i < 3 * BPF + 3; i++) begin
            drive(i < 3 * BPF, rand48());
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_mis++;
                $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
        end
        // new frame beat lands exactly on the frame_done cycle with new config
        for (int i = 0; i < 2 * BPF + 4; i++) begin
            cfg_mode = (i < BPF) ? 3'd1 : 3'd2;
            cfg_value = 8'd90;
            drive((i < BPF) || (i > BPF && i <= 2 * BPF), rand48());
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_mis++;
                $display("FAIL fd_restart cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_modes_random();
        for (int m = 0; m < 8; m++) begin
            cfg_mode = 3'(m); cfg_value = 8'($urandom_range(0, 255));
            cfg_value_ovr = 1'($urandom_range(0, 1));
            for (int i = 0; i < BPF + 3; i++) begin
                drive(i < BPF, rand48());
                n_cmp++;
                if (obs_vec !== exp_vec) begin
                    n_mis++;
                    $display("FAIL modes m=%0d cyc=%0d got=%h exp=%h", m, cyc, obs_vec, exp_vec);
                end
            end
        end
    endtask

    task automatic test_threshold();
        logic [47:0] want;
        cfg_mode = 3'd4; cfg_value = 8'd90; cfg_value_ovr = 1'b1;
`ifdef PIX_THRESHOLD_EN
        want = {24'hFFFFFF, 24'h000000};
`else
        want = {8'd100, 8'd100, 8'd71, 8'd90, 8'd90, 8'd90};
`endif
        for (int i = 0; i < BPF + 3; i++) begin
            drive(i < BPF, {8'd100, 8'd100, 8'd71, 8'd90, 8'd90, 8'd90});
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_mis++;
                $display("FAIL thr cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
            end
            if (i >= 1 && i <= BPF) begin
                n_cmp++;
                if (obs_vec[47:0] !== want) begin
                    n_mis++;
                    $display("FAIL thr_const got=%h exp=%h", obs_vec[47:0], want);
                end
            end
        end
    endtask

    initial begin
        cyc = 0; n_cmp = 0; n_mis = 0;
        mdl_mode = 0; mdl_val = 100;
        test_reset();
        test_add_default();
        test_sub_inv();
        test_bubble();
        test_cfg_hold();
        test_reset_midframe();
        test_back_to_back();
        test_modes_random();
        test_threshold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
